// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Store byte-enable/replication and load extension live here so the top stays FSM-only.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } dmr_state_e;

  function automatic logic [3:0] store_be(input logic [1:0] addr, input size_e size);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << addr;
      SZ_H:    be = 4'b0011 << addr;
      SZ_W:    be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

  // Right-aligned store data is replicated so every enabled lane sees its bytes.
  function automatic logic [31:0] store_data(input logic [31:0] wdata, input size_e size);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input size_e size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port synchronous RAM with per-byte write enables and READ_LAT output stages.
// Storage and read pipeline carry no reset.
module dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned READ_LAT    = 1,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q  [DEPTH_WORDS];
  logic [31:0] pipe_q [READ_LAT];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Stage 0 only loads on a read so stores never disturb a pending result.
  always_ff @(posedge clk_i) begin
    if (re_i) pipe_q[0] <= mem_q[addr_i];
    for (int unsigned s = 1; s < READ_LAT; s++) begin
      pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign rdata_o = pipe_q[READ_LAT-1];

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the memory-access stage: one request at a time, byte-enable stores,
// extended loads returned as a single-cycle response pulse, with alignment/range errors.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [1:0]  LAT_INIT   = 2'(READ_LAT - 1);

  dmr_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic        ld_q, ld_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;

  size_e       req_sz;
  logic        accept;
  logic        req_err;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  assign req_sz    = size_e'(req_size);
  assign req_ready = (state_q != RD_WAIT);
  assign busy      = ~req_ready;
  assign accept    = req_valid && req_ready;

  assign req_err = (req_size == 2'd3)
                 | ((req_sz == SZ_H) && req_addr[0])
                 | ((req_sz == SZ_W) && (req_addr[1:0] != 2'b00))
                 | ({1'b0, req_addr} >= ADDR_LIMIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    size_d     = size_q;
    uns_d      = uns_q;
    ld_d       = ld_q;
    resp_err_d = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    case (state_q)
      RD_WAIT: begin
        if (cnt_q == 2'd1) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          lane_d = req_addr[1:0];
          size_d = req_sz;
          uns_d  = req_unsigned;
          ld_d   = !req_we && !req_err;
          if (req_err) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else if (req_we) begin
            ram_we  = rstn;
            state_d = RESP;
          end else begin
            ram_re = rstn;
            if (READ_LAT == 1) begin
              state_d = RESP;
            end else begin
              state_d = RD_WAIT;
              cnt_d   = LAT_INIT;
            end
          end
        end
      end
    endcase
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lane_q       <= '0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      ld_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      ld_q         <= ld_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .READ_LAT    (READ_LAT)
  ) u_bram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (req_addr[AW+1:2]),
    .be_i    (store_be(req_addr[1:0], req_sz)),
    .wdata_i (store_data(req_wdata, req_sz)),
    .rdata_o (ram_rdata)
  );

  // The RAM output stage is itself the data register; extension is gated by registered flags.
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = (resp_valid_q && ld_q) ? load_extend(ram_rdata, lane_q, size_q, uns_q) : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: two responders (READ_LAT 1 and 3) share one request stream.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;

  logic        rdy1, rv1, err1, busy1;
  logic [31:0] rd1;
  logic        rdy3, rv3, err3, busy3;
  logic [31:0] rd3;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LAT(1)) dut1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .busy(busy1)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LAT(3)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3), .busy(busy3)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [21];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_cycle(input string tag, input int c, input int lat, input logic v,
                           input logic [31:0] rd, input logic e,
                           input logic [31:0] exp_rd, input logic exp_e);
    chk($sformatf("%s c%0d valid", tag, c), {31'h0, v}, {31'h0, c == lat});
    if (c == lat) begin
      chk($sformatf("%s rdata", tag), rd, exp_rd);
      chk($sformatf("%s err", tag), {31'h0, e}, {31'h0, exp_e});
    end else begin
      chk($sformatf("%s c%0d rdata idle", tag, c), rd, 32'h0);
      chk($sformatf("%s c%0d err idle", tag, c), {31'h0, e}, 32'h0);
    end
  endtask

  task automatic do_req(input string tag, input vec_t v);
    int lat3;
    lat3 = (v.we || v.exp_err) ? 1 : 3;
    @(negedge clk);
    chk({tag, " ready1"}, {31'h0, rdy1}, 32'h1);
    chk({tag, " ready3"}, {31'h0, rdy3}, 32'h1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    for (int c = 1; c <= 4; c++) begin
      chk_cycle({tag, " L1"}, c, 1, rv1, rd1, err1, v.exp_rdata, v.exp_err);
      chk_cycle({tag, " L3"}, c, lat3, rv3, rd3, err3, v.exp_rdata, v.exp_err);
      if (c == 2) chk({tag, " busy3"}, {31'h0, busy3}, {31'h0, lat3 == 3});
      if (c < 4) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b0, 32'h13,  32'h0,        2'd0, 1'b0, 32'hFFFFFFDE, 1'b0);
    vecs[3]  = mk(1'b0, 32'h13,  32'h0,        2'd0, 1'b1, 32'h000000DE, 1'b0);
    vecs[4]  = mk(1'b0, 32'h10,  32'h0,        2'd1, 1'b0, 32'hFFFFBEEF, 1'b0);
    vecs[5]  = mk(1'b0, 32'h12,  32'h0,        2'd1, 1'b1, 32'h0000DEAD, 1'b0);
    vecs[6]  = mk(1'b1, 32'h11,  32'hAAAAAA55, 2'd0, 1'b0, 32'h0,        1'b0);
    vecs[7]  = mk(1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEAD55EF, 1'b0);
    vecs[8]  = mk(1'b0, 32'h11,  32'h0,        2'd1, 1'b0, 32'h0,        1'b1);
    vecs[9]  = mk(1'b0, 32'h12,  32'h0,        2'd2, 1'b0, 32'h0,        1'b1);
    vecs[10] = mk(1'b0, 32'h10,  32'h0,        2'd3, 1'b0, 32'h0,        1'b1);
    vecs[11] = mk(1'b0, 32'h400, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1);
    vecs[12] = mk(1'b1, 32'h10,  32'h0,        2'd3, 1'b0, 32'h0,        1'b1);
    vecs[13] = mk(1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEAD55EF, 1'b0);
    vecs[14] = mk(1'b1, 32'h12,  32'hFFFF1234, 2'd1, 1'b0, 32'h0,        1'b0);
    vecs[15] = mk(1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'h123455EF, 1'b0);
    vecs[16] = mk(1'b0, 32'h10,  32'h0,        2'd0, 1'b0, 32'hFFFFFFEF, 1'b0);
    vecs[17] = mk(1'b0, 32'h11,  32'h0,        2'd0, 1'b0, 32'h00000055, 1'b0);
    vecs[18] = mk(1'b1, 32'h3FC, 32'hCAFEF00D, 2'd2, 1'b0, 32'h0,        1'b0);
    vecs[19] = mk(1'b0, 32'h3FC, 32'h0,        2'd2, 1'b0, 32'hCAFEF00D, 1'b0);
    vecs[20] = mk(1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 32'h00001234, 1'b0);

    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("reset valid1", {31'h0, rv1}, 32'h0);
    chk("reset rdata1", rd1, 32'h0);
    chk("reset err1", {31'h0, err1}, 32'h0);
    chk("reset ready1", {31'h0, rdy1}, 32'h1);
    chk("reset valid3", {31'h0, rv3}, 32'h0);
    chk("reset ready3", {31'h0, rdy3}, 32'h1);
    chk("reset busy3", {31'h0, busy3}, 32'h0);

    for (int i = 0; i < 21; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i]);
    end

    // Four stores back-to-back with req_valid held high
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h20 + 32'(4 * k); req_wdata = 32'hA0B0_0000 + 32'(k);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d valid1", k), {31'h0, rv1}, 32'h1);
      chk($sformatf("b2b%0d valid3", k), {31'h0, rv3}, 32'h1);
      chk($sformatf("b2b%0d ready1", k), {31'h0, rdy1}, 32'h1);
      chk($sformatf("b2b%0d ready3", k), {31'h0, rdy3}, 32'h1);
      chk($sformatf("b2b%0d rdata3", k), rd3, 32'h0);
      chk($sformatf("b2b%0d err3", k), {31'h0, err3}, 32'h0);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b end valid1", {31'h0, rv1}, 32'h0);
    chk("b2b end valid3", {31'h0, rv3}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      do_req($sformatf("b2b rd%0d", k),
             mk(1'b0, 32'h20 + 32'(4 * k), 32'h0, 2'd2, 1'b0, 32'hA0B0_0000 + 32'(k), 1'b0));
    end

    // Reset while the 3-cycle load is still in flight
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst-rd L1 valid", {31'h0, rv1}, 32'h1);
    chk("rst-rd L1 rdata", rd1, 32'h123455EF);
    chk("rst-rd L3 busy", {31'h0, busy3}, 32'h1);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst-rd valid1", {31'h0, rv1}, 32'h0);
    chk("rst-rd valid3", {31'h0, rv3}, 32'h0);
    chk("rst-rd ready3", {31'h0, rdy3}, 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst-rd quiet%0d valid3", c), {31'h0, rv3}, 32'h0);
      chk($sformatf("rst-rd quiet%0d ready3", c), {31'h0, rdy3}, 32'h1);
    end
    do_req("rst-rd reread", mk(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h123455EF, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
